// File: rtl/mem_ctrl_pkg.sv
// Shared types for the data-memory access controller: opcodes, FSM states,
// memory geometry and request-decode helpers.
package mem_ctrl_pkg;

  localparam int unsigned WADDR_W = 15;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [2:0] {
    LW  = 3'd0,
    LH  = 3'd1,
    LHU = 3'd2,
    LB  = 3'd3,
    LBU = 3'd4,
    SW  = 3'd5,
    SH  = 3'd6,
    SB  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Word ops need a word-aligned address, half ops a half-aligned one.
  function automatic logic is_misaligned(input op_t op, input logic [1:0] byte_off);
    case (op)
      LW, SW:      is_misaligned = (byte_off != 2'b00);
      LH, LHU, SH: is_misaligned = byte_off[0];
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic is_subword_store(input op_t op);
    is_subword_store = (op == SH) || (op == SB);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends load lanes, and merges
// sub-word store data into the word read back from memory.
module lsu_lane_align
  import mem_ctrl_pkg::*;
(
  input  op_t               i_op,
  input  logic [1:0]        i_byte_off,
  input  logic [WORD_W-1:0] i_mem_rdata,
  input  logic [15:0]       i_st_data,
  output logic [WORD_W-1:0] o_ld_data,
  output logic [WORD_W-1:0] o_st_word
);

  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Little-endian lane offsets in bits.
  assign w_byte_sh = {i_byte_off, 3'b000};
  assign w_half_sh = {i_byte_off[1], 4'b0000};
  assign w_byte    = i_mem_rdata[w_byte_sh +: 8];
  assign w_half    = i_mem_rdata[w_half_sh +: 16];

  always_comb begin
    o_ld_data = '0;
    case (i_op)
      LW:      o_ld_data = i_mem_rdata;
      LH:      o_ld_data = {{16{w_half[15]}}, w_half};
      LHU:     o_ld_data = {16'h0000, w_half};
      LB:      o_ld_data = {{24{w_byte[7]}}, w_byte};
      LBU:     o_ld_data = {24'h000000, w_byte};
      default: o_ld_data = '0;
    endcase
  end

  always_comb begin
    o_st_word = i_mem_rdata;
    if (i_op == SB) begin
      o_st_word[w_byte_sh +: 8] = i_st_data[7:0];
    end else if (i_op == SH) begin
      o_st_word[w_half_sh +: 16] = i_st_data;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Initiator side of the data-memory port: one load/store at a time, with
// read-modify-write for sub-word stores and a held response handshake.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned BADDR_W = 17,
  parameter int unsigned DATA_W  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  op_t                req_op,
  input  logic [BADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic               rsp_err,
  output logic [WADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  state_t              r_state;
  state_t              w_next_state;
  op_t                 r_op;
  logic [1:0]          r_byte_off;
  logic [15:0]         r_st_data;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;
  logic [WADDR_W-1:0]  r_mem_addr;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic                w_accept;
  logic                w_misaligned;
  logic [WORD_W-1:0]   w_ld_data;
  logic [WORD_W-1:0]   w_st_word;

  assign w_accept     = req_valid & r_req_ready;
  assign w_misaligned = is_misaligned(req_op, req_addr[1:0]);

  lsu_lane_align u_lane (
    .i_op        (r_op),
    .i_byte_off  (r_byte_off),
    .i_mem_rdata (WORD_W'(mem_rdata)),
    .i_st_data   (r_st_data),
    .o_ld_data   (w_ld_data),
    .o_st_word   (w_st_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_misaligned) begin
            w_next_state = ST_RESP;
          end else if (req_op == SW) begin
            w_next_state = ST_WR;
          end else begin
            w_next_state = ST_RD;
          end
        end
      end
      ST_RD:   w_next_state = is_subword_store(r_op) ? ST_WR : ST_RESP;
      ST_WR:   w_next_state = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Handshake and write-enable flags are registered copies of the next state,
  // so mem_we comes straight off a flop and cannot glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_mem_we    <= 1'b0;
    end else begin
      r_req_ready <= (w_next_state == ST_IDLE);
      r_rsp_valid <= (w_next_state == ST_RESP);
      r_mem_we    <= (w_next_state == ST_WR);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op        <= LW;
      r_byte_off  <= 2'b00;
      r_st_data   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op        <= req_op;
            r_byte_off  <= req_addr[1:0];
            r_st_data   <= req_wdata[15:0];
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_misaligned;
            if (!w_misaligned) begin
              r_mem_addr <= WADDR_W'(req_addr[BADDR_W-1:2]);
              if (req_op == SW) begin
                r_mem_wdata <= req_wdata;
              end
            end
          end
        end
        ST_RD: begin
          if (is_subword_store(r_op)) begin
            r_mem_wdata <= DATA_W'(w_st_word);
          end else begin
            r_rsp_rdata <= DATA_W'(w_ld_data);
          end
        end
        default: ;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl against a word memory preloaded ram[i]=i.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  op_t         req_op;
  logic [16:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:32767];
  rsp_t        exp_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.BADDR_W(17), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: a response handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
        check("rsp_err", 64'(rsp_err), 64'(e.err));
      end
    end
  end

  // Issue one request; exp_we_cyc=0 means no write expected.
  task automatic do_req(input op_t op, input logic [16:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_we_cyc, input logic [31:0] exp_wdata,
                        input logic [14:0] exp_maddr, input int hold);
    int lat = 0, we_cnt = 0, we_cyc = 0;
    logic [31:0] we_data = '0;
    logic [14:0] addr1 = '0;
    check("req_ready_idle", 64'(req_ready), 64'(1));
    exp_q.push_back('{rdata: exp_rdata, err: exp_err});
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = LB; req_addr = 17'h1FFFF; req_wdata = 32'hFFFF_FFFF;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (mem_we) begin we_cnt++; we_cyc = n; we_data = mem_wdata; end
      if (n == 1) addr1 = mem_addr;
      if (rsp_valid) begin lat = n; break; end
    end
    check("rsp_latency", 64'(lat), 64'(exp_lat));
    check("mem_we_count", 64'(we_cnt), 64'((exp_we_cyc != 0) ? 1 : 0));
    if (exp_we_cyc != 0) begin
      check("mem_we_cycle", 64'(we_cyc), 64'(exp_we_cyc));
      check("mem_wdata", 64'(we_data), 64'(exp_wdata));
    end
    if (!exp_err) check("mem_addr_c1", 64'(addr1), 64'(exp_maddr));
    for (int h = 0; h < hold; h++) begin
      check("hold_stable", {30'd0, req_ready, rsp_valid, rsp_rdata}, {30'd0, 1'b0, 1'b1, exp_rdata});
      @(negedge clk);
    end
    if (hold != 0) begin
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 32'(i);
    rst = 1'b1; req_valid = 1'b0; req_op = LW; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #12;
    check("reset_outputs", {req_ready, rsp_valid, rsp_err, mem_we, mem_addr, rsp_rdata | mem_wdata},
                           {1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 32'd0});
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // 1: plain word load
    do_req(LW, 17'h00010, 32'h0, 32'h0000_0004, 1'b0, 2, 0, 32'h0, 15'h0004, 0);
    // 2: byte store via RMW, then read back in several widths
    do_req(SB, 17'h00021, 32'h0000_00AB, 32'h0, 1'b0, 3, 2, 32'h0000_AB08, 15'h0008, 0);
    do_req(LW,  17'h00020, 32'h0, 32'h0000_AB08, 1'b0, 2, 0, 32'h0, 15'h0008, 0);
    do_req(LB,  17'h00021, 32'h0, 32'hFFFF_FFAB, 1'b0, 2, 0, 32'h0, 15'h0008, 0);
    do_req(LBU, 17'h00021, 32'h0, 32'h0000_00AB, 1'b0, 2, 0, 32'h0, 15'h0008, 0);
    do_req(LH,  17'h00020, 32'h0, 32'hFFFF_AB08, 1'b0, 2, 0, 32'h0, 15'h0008, 0);
    do_req(LHU, 17'h00020, 32'h0, 32'h0000_AB08, 1'b0, 2, 0, 32'h0, 15'h0008, 0);
    // 3: misaligned half load and word store
    do_req(LH, 17'h00013, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0, 15'h0, 0);
    do_req(SW, 17'h00042, 32'h1234_5678, 32'h0, 1'b1, 1, 0, 32'h0, 15'h0, 0);
    // 4: response back-pressure
    do_req(LW, 17'h00008, 32'h0, 32'h0000_0002, 1'b0, 2, 0, 32'h0, 15'h0002, 5);
    // upper half store into word 1, top-of-range word load
    do_req(SH, 17'h00006, 32'hFFFF_8001, 32'h0, 1'b0, 3, 2, 32'h8001_0001, 15'h0001, 0);
    do_req(LW, 17'h00004, 32'h0, 32'h8001_0001, 1'b0, 2, 0, 32'h0, 15'h0001, 0);
    do_req(LW, 17'h1FFFC, 32'h0, 32'h0000_7FFF, 1'b0, 2, 0, 32'h0, 15'h7FFF, 0);

    // 5: reset during the RD cycle of an SH abandons the write
    req_valid = 1'b1; req_op = SH; req_addr = 17'h00032; req_wdata = 32'h0000_1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_we_before", 64'(mem_we), 64'(0));
    rst = 1'b1; #1;
    check("rst_mid_outputs", {req_ready, rsp_valid, rsp_err, mem_we, mem_addr, rsp_rdata | mem_wdata},
                             {1'b1, 1'b0, 1'b0, 1'b0, 15'd0, 32'd0});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_hold_we", 64'(mem_we), 64'(0));
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    do_req(LW, 17'h00030, 32'h0, 32'h0000_000C, 1'b0, 2, 0, 32'h0, 15'h000C, 0);

    // 6: back-to-back store then load
    do_req(SW, 17'h00040, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1, 32'hDEAD_BEEF, 15'h0010, 0);
    do_req(LW, 17'h00040, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 0, 32'h0, 15'h0010, 0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
